ula_arbiter: RTL and testbench

- Shares one combinational ULA instance between two requesters: the pipeline EX stage (requester 0) and the multi-cycle co-processor / IO unit (requester 1).
- Arbitrates round-robin and registers the operands. Holds them stable for an op-dependent number of cycles, so MUL and DIV run as multicycle paths.
- Returns registered results tagged to the requester.
- Sits between the requesters and the ULA, and owns the ULA's ALUop, D1 and D2 inputs.

---
 rtl/ula_pkg.sv | 40 ++++
 rtl/ula_rr_grant.sv | 23 ++
 rtl/ula_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ula_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared ULA definitions: op encodings, op width, arbiter state type and
// the operand-hold length helper.
package ula_pkg;

    localparam int ULA_OP_W = 4;

    localparam logic [ULA_OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [ULA_OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [ULA_OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [ULA_OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [ULA_OP_W-1:0] OP_NOT  = 4'b0100;
    localparam logic [ULA_OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [ULA_OP_W-1:0] OP_OR   = 4'b0110;
    localparam logic [ULA_OP_W-1:0] OP_XOR  = 4'b0111;
    localparam logic [ULA_OP_W-1:0] OP_SLT  = 4'b1000;
    localparam logic [ULA_OP_W-1:0] OP_SGT  = 4'b1001;
    localparam logic [ULA_OP_W-1:0] OP_BEQ  = 4'b1010;
    localparam logic [ULA_OP_W-1:0] OP_BNEQ = 4'b1011;
    localparam logic [ULA_OP_W-1:0] OP_SR   = 4'b1100;
    localparam logic [ULA_OP_W-1:0] OP_SL   = 4'b1101;

    typedef enum logic {
        ST_IDLE,
        ST_EXEC
    } arb_state_e;

    // Number of EXEC cycles the operands must stay on the ULA inputs.
    function automatic logic [3:0] op_hold_cycles(
        input logic [ULA_OP_W-1:0] op,
        input int                  mul_cycles,
        input int                  div_cycles
    );
        logic [3:0] len;
        len = 4'd1;
        if (op == OP_MUL) len = 4'(mul_cycles);
        if (op == OP_DIV) len = 4'(div_cycles);
        return len;
    endfunction

endpackage

// File: rtl/ula_rr_grant.sv
// Combinational two-way grant. Round-robin on last_i by default; fixed
// priority to requester 0 when ULA_ARB_FIXED_PRIO_EN is defined.
module ula_rr_grant (
    input  logic [1:0] valid_i,
`ifndef ULA_ARB_FIXED_PRIO_EN
    input  logic       last_i,
`endif
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
            grant_o = 2'b01;
`else
            // last_i names the requester served most recently; favour the other.
            grant_o = last_i ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester front end for the shared combinational ULA: grants, holds
// operands for the op's multicycle length, returns tagged registered results.
// Optional build macro: ULA_ARB_FIXED_PRIO_EN (fixed priority, no LAST).
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            REQ_VALID,
    input  logic [2*ULA_OP_W-1:0] REQ_OP,
    input  logic [2*DATA_W-1:0]   REQ_A,
    input  logic [2*DATA_W-1:0]   REQ_B,
    output logic [1:0]            REQ_READY,
    output logic [1:0]            RSP_VALID,
    output logic [DATA_W-1:0]     RSP_RESULT,
    output logic [DATA_W-1:0]     RSP_RESTO,
    output logic                  RSP_ZERO,
    output logic [ULA_OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0]     ALU_D1,
    output logic [DATA_W-1:0]     ALU_D2,
    input  logic [DATA_W-1:0]     ALU_RESULT,
    input  logic [DATA_W-1:0]     ALU_RESTO,
    input  logic                  ALU_ZERO
);

    arb_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic [ULA_OP_W-1:0] alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_d1_q, alu_d1_d;
    logic [DATA_W-1:0]   alu_d2_q, alu_d2_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [DATA_W-1:0]   rsp_resto_q, rsp_resto_d;
    logic                rsp_zero_q, rsp_zero_d;
`ifndef ULA_ARB_FIXED_PRIO_EN
    logic                last_q, last_d;
`endif

    logic [1:0]          grant;
    logic                sel;
    logic [ULA_OP_W-1:0] sel_op;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [DATA_W-1:0]   cap_result, cap_resto;
    logic                cap_zero;

    ula_rr_grant u_grant (
        .valid_i (REQ_VALID),
`ifndef ULA_ARB_FIXED_PRIO_EN
        .last_i  (last_q),
`endif
        .grant_o (grant)
    );

    assign REQ_READY = (state_q == ST_IDLE) ? (REQ_VALID & grant) : 2'b00;

    assign sel    = REQ_READY[1];
    assign sel_op = sel ? REQ_OP[2*ULA_OP_W-1:ULA_OP_W] : REQ_OP[ULA_OP_W-1:0];
    assign sel_a  = sel ? REQ_A[2*DATA_W-1:DATA_W] : REQ_A[DATA_W-1:0];
    assign sel_b  = sel ? REQ_B[2*DATA_W-1:DATA_W] : REQ_B[DATA_W-1:0];

    // Divide-by-zero and the two undefined ops never use the ULA outputs.
    always_comb begin
        cap_result = ALU_RESULT;
        cap_resto  = ALU_RESTO;
        cap_zero   = ALU_ZERO;
        if (alu_op_q == OP_DIV && alu_d2_q == '0) begin
            cap_result = '1;
            cap_resto  = alu_d1_q;
            cap_zero   = 1'b0;
        end else if (alu_op_q[3:1] == 3'b111) begin
            cap_result = '0;
            cap_resto  = '0;
            cap_zero   = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        alu_op_d     = alu_op_q;
        alu_d1_d     = alu_d1_q;
        alu_d2_d     = alu_d2_q;
        rsp_valid_d  = 2'b00;
        rsp_result_d = rsp_result_q;
        rsp_resto_d  = rsp_resto_q;
        rsp_zero_d   = rsp_zero_q;
`ifndef ULA_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|REQ_READY) begin
                    alu_op_d = sel_op;
                    alu_d1_d = sel_a;
                    alu_d2_d = sel_b;
                    owner_d  = sel;
                    cnt_d    = op_hold_cycles(sel_op, MUL_CYCLES, DIV_CYCLES) - 4'd1;
                    state_d  = ST_EXEC;
`ifndef ULA_ARB_FIXED_PRIO_EN
                    last_d   = sel;
`endif
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                    rsp_result_d = cap_result;
                    rsp_resto_d  = cap_resto;
                    rsp_zero_d   = cap_zero;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            alu_op_q     <= '0;
            alu_d1_q     <= '0;
            alu_d2_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_resto_q  <= '0;
            rsp_zero_q   <= 1'b0;
`ifndef ULA_ARB_FIXED_PRIO_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            alu_op_q     <= alu_op_d;
            alu_d1_q     <= alu_d1_d;
            alu_d2_q     <= alu_d2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_resto_q  <= rsp_resto_d;
            rsp_zero_q   <= rsp_zero_d;
`ifndef ULA_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    assign ALU_OP     = alu_op_q;
    assign ALU_D1     = alu_d1_q;
    assign ALU_D2     = alu_d2_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RESULT = rsp_result_q;
    assign RSP_RESTO  = rsp_resto_q;
    assign RSP_ZERO   = rsp_zero_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA, transaction-level reference model
// checked every cycle, table-driven vectors, hand sequences, random traffic.
module tb_ula_arbiter;

    localparam int W     = 32;
    localparam int MUL_C = 2;
    localparam int DIV_C = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   REQ_VALID = 2'b00;
    logic [7:0]   REQ_OP = '0;
    logic [2*W-1:0] REQ_A = '0;
    logic [2*W-1:0] REQ_B = '0;
    logic [1:0]   REQ_READY;
    logic [1:0]   RSP_VALID;
    logic [W-1:0] RSP_RESULT, RSP_RESTO;
    logic         RSP_ZERO;
    logic [3:0]   ALU_OP;
    logic [W-1:0] ALU_D1, ALU_D2;
    logic [W-1:0] ALU_RESULT, ALU_RESTO;
    logic         ALU_ZERO;

    int checks = 0;
    int errors = 0;

    ula_arbiter #(.DATA_W(W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clock      (clock),
        .reset      (reset),
        .REQ_VALID  (REQ_VALID),
        .REQ_OP     (REQ_OP),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_RESULT (RSP_RESULT),
        .RSP_RESTO  (RSP_RESTO),
        .RSP_ZERO   (RSP_ZERO),
        .ALU_OP     (ALU_OP),
        .ALU_D1     (ALU_D1),
        .ALU_D2     (ALU_D2),
        .ALU_RESULT (ALU_RESULT),
        .ALU_RESTO  (ALU_RESTO),
        .ALU_ZERO   (ALU_ZERO)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] resto;
        logic         zero;
    } ula_out_t;

    // Stand-in ULA; div-by-zero and undefined ops return junk on purpose.
    function automatic ula_out_t ula_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ula_out_t o;
        o = '0;
        case (op)
            4'd0:  o.res = a + b;
            4'd1:  o.res = a - b;
            4'd2:  o.res = a * b;
            4'd3: begin
                if (b != 0) begin
                    o.res = a / b;
                    o.resto = a % b;
                end else begin
                    o.res = 32'hDEAD_BEEF;
                    o.resto = 32'h1111_1111;
                    o.zero = 1'b1;
                end
            end
            4'd4:  o.res = ~a;
            4'd5:  o.res = a & b;
            4'd6:  o.res = a | b;
            4'd7:  o.res = a ^ b;
            4'd8:  o.res = {31'b0, $signed(a) < $signed(b)};
            4'd9:  o.res = {31'b0, $signed(a) > $signed(b)};
            4'd10: begin o.res = a - b; o.zero = (a == b); end
            4'd11: begin o.res = a - b; o.zero = (a != b); end
            4'd12: o.res = a >> b;
            4'd13: o.res = a << b;
            default: begin o.res = 32'hA5A5_5A5A; o.resto = 32'h5A5A; o.zero = 1'b1; end
        endcase
        return o;
    endfunction

    always_comb begin
        ula_out_t u;
        u = ula_fn(ALU_OP, ALU_D1, ALU_D2);
        ALU_RESULT = u.res;
        ALU_RESTO  = u.resto;
        ALU_ZERO   = u.zero;
    end

    function automatic ula_out_t expect_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ula_out_t o;
        if (op == 4'd3 && b == 0) begin
            o.res = '1; o.resto = a; o.zero = 1'b0;
        end else if (op >= 4'd14) begin
            o = '0;
        end else begin
            o = ula_fn(op, a, b);
        end
        return o;
    endfunction

    function automatic int hold_len(input logic [3:0] op);
        if (op == 4'd2) return MUL_C;
        if (op == 4'd3) return DIV_C;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles, last-served id, expected-result queue.
    logic [W*2:0] exp_q[$];
    int           rem = 0;
    int           m_owner = 0;
    logic         m_last = 1'b1;
    logic         m_rsp_due = 1'b0;
    logic [3:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    ula_out_t     m_exp = '0;

    always @(negedge clock) begin
        logic [1:0] g;
        int n;
        if (reset) begin
            rem = 0; m_owner = 0; m_last = 1'b1; m_rsp_due = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; m_exp = '0;
            exp_q.delete();
        end else begin
            if (m_rsp_due && exp_q.size() > 0) m_exp = exp_q.pop_front();
            g = 2'b00;
            if (rem == 0) begin
                g = REQ_VALID;
`ifdef ULA_ARB_FIXED_PRIO_EN
                if (REQ_VALID == 2'b11) g = 2'b01;
`else
                if (REQ_VALID == 2'b11) g = m_last ? 2'b01 : 2'b10;
`endif
            end
            chk("m_ready", 64'(REQ_READY), 64'(g));
            chk("m_rsp_valid", 64'(RSP_VALID), m_rsp_due ? 64'(m_owner ? 2'b10 : 2'b01) : 64'd0);
            chk("m_rsp_result", 64'(RSP_RESULT), 64'(m_exp.res));
            chk("m_rsp_resto", 64'(RSP_RESTO), 64'(m_exp.resto));
            chk("m_rsp_zero", 64'(RSP_ZERO), 64'(m_exp.zero));
            chk("m_alu_op", 64'(ALU_OP), 64'(m_op));
            chk("m_alu_d1", 64'(ALU_D1), 64'(m_a));
            chk("m_alu_d2", 64'(ALU_D2), 64'(m_b));
            m_rsp_due = (rem == 1);
            if (rem == 1) exp_q.push_back(expect_fn(m_op, m_a, m_b));
            if (rem > 0) begin
                rem--;
            end else if (g != 2'b00) begin
                n = g[1] ? 1 : 0;
                m_op = REQ_OP[4*n +: 4];
                m_a = REQ_A[W*n +: W];
                m_b = REQ_B[W*n +: W];
                m_owner = n;
                m_last = g[1];
                rem = hold_len(m_op);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        REQ_VALID = 2'b00;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drive(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        REQ_OP[4*n +: 4] = op;
        REQ_A[W*n +: W] = a;
        REQ_B[W*n +: W] = b;
    endtask

    typedef struct {
        int         req;
        logic [3:0] op;
        logic [W-1:0] a, b, res, resto;
        logic       zero;
    } vec_t;

    vec_t vecs[16];

    task automatic run_vec(input vec_t v);
        bit got;
        @(posedge clock); #1;
        drive(v.req, v.op, v.a, v.b);
        REQ_VALID = (v.req == 1) ? 2'b10 : 2'b01;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (REQ_READY[v.req]) got = 1;
        end
        if (!got) chk("vec_ready_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if (RSP_VALID != 2'b00) got = 1;
        end
        if (!got) begin
            chk("vec_rsp_timeout", 64'd0, 64'd1);
        end else begin
            chk("vec_rsp_valid", 64'(RSP_VALID), 64'(v.req == 1 ? 2'b10 : 2'b01));
            chk("vec_result", 64'(RSP_RESULT), 64'(v.res));
            chk("vec_resto", 64'(RSP_RESTO), 64'(v.resto));
            chk("vec_zero", 64'(RSP_ZERO), 64'(v.zero));
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        vecs[0]  = '{0, 4'd0,  32'd5,         32'd7,  32'd12,        32'd0, 1'b0};
        vecs[1]  = '{1, 4'd1,  32'd10,        32'd3,  32'd7,         32'd0, 1'b0};
        vecs[2]  = '{0, 4'd2,  32'd6,         32'd7,  32'd42,        32'd0, 1'b0};
        vecs[3]  = '{1, 4'd3,  32'd17,        32'd5,  32'd3,         32'd2, 1'b0};
        vecs[4]  = '{0, 4'd3,  32'd9,         32'd0,  32'hFFFF_FFFF, 32'd9, 1'b0};
        vecs[5]  = '{1, 4'd4,  32'h0F0F_0F0F, 32'd0,  32'hF0F0_F0F0, 32'd0, 1'b0};
        vecs[6]  = '{0, 4'd5,  32'hF0,        32'h3C, 32'h30,        32'd0, 1'b0};
        vecs[7]  = '{1, 4'd6,  32'hF0,        32'h0F, 32'hFF,        32'd0, 1'b0};
        vecs[8]  = '{0, 4'd7,  32'hFF,        32'h0F, 32'hF0,        32'd0, 1'b0};
        vecs[9]  = '{1, 4'd8,  32'hFFFF_FFFF, 32'd1,  32'd1,         32'd0, 1'b0};
        vecs[10] = '{0, 4'd9,  32'd5,         32'd3,  32'd1,         32'd0, 1'b0};
        vecs[11] = '{1, 4'd10, 32'd4,         32'd4,  32'd0,         32'd0, 1'b1};
        vecs[12] = '{0, 4'd11, 32'd4,         32'd5,  32'hFFFF_FFFF, 32'd0, 1'b1};
        vecs[13] = '{1, 4'd12, 32'h80,        32'd3,  32'h10,        32'd0, 1'b0};
        vecs[14] = '{0, 4'd14, 32'd7,         32'd7,  32'd0,         32'd0, 1'b0};
        vecs[15] = '{1, 4'd15, 32'd1,         32'd0,  32'd0,         32'd0, 1'b0};

        // Reset state, then a single ADD.
        do_reset();
        @(negedge clock);
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
        chk("rst_alu_op", 64'(ALU_OP), 64'd0);
        chk("rst_alu_d1", 64'(ALU_D1), 64'd0);
        chk("rst_alu_d2", 64'(ALU_D2), 64'd0);
        chk("rst_rsp_result", 64'(RSP_RESULT), 64'd0);
        @(posedge clock); #1;
        drive(0, 4'd0, 32'd5, 32'd7);
        REQ_VALID = 2'b01;
        @(negedge clock);
        chk("add_ready", 64'(REQ_READY), 64'd1);
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        @(negedge clock);
        chk("add_alu_op", 64'(ALU_OP), 64'd0);
        chk("add_alu_d1", 64'(ALU_D1), 64'd5);
        @(negedge clock);
        chk("add_rsp_valid", 64'(RSP_VALID), 64'd1);
        chk("add_result", 64'(RSP_RESULT), 64'd12);

        // Contention: both requesters valid every cycle.
        do_reset();
        drive(0, 4'd1, 32'd10, 32'd3);
        drive(1, 4'd6, 32'hF0, 32'h0F);
        REQ_VALID = 2'b11;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
`ifdef ULA_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("cont_ready", 64'(REQ_READY), (c % 2 == 0) ? 64'(exp_g) : 64'd0);
            if (c >= 2 && c % 2 == 0) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
                exp_g = 2'b01;
`else
                exp_g = ((c / 2 - 1) % 2 == 0) ? 2'b01 : 2'b10;
`endif
                chk("cont_rsp_valid", 64'(RSP_VALID), 64'(exp_g));
                chk("cont_result", 64'(RSP_RESULT), exp_g[0] ? 64'd7 : 64'hFF);
            end else begin
                chk("cont_rsp_idle", 64'(RSP_VALID), 64'd0);
            end
        end
        @(posedge clock); #1;
        REQ_VALID = 2'b00;

        // Multicycle DIV on requester 1; request inputs wiggle during EXEC.
        do_reset();
        drive(1, 4'd3, 32'd17, 32'd5);
        REQ_VALID = 2'b10;
        @(negedge clock);
        chk("div_ready", 64'(REQ_READY), 64'd2);
        @(posedge clock); #1;
        drive(1, 4'd0, 32'd99, 32'd1);
        drive(0, 4'd1, 32'd8, 32'd2);
        REQ_VALID = 2'b11;
        for (int c = 1; c <= DIV_C; c++) begin
            @(negedge clock);
            chk("div_busy_ready", 64'(REQ_READY), 64'd0);
            chk("div_alu_op", 64'(ALU_OP), 64'd3);
            chk("div_alu_d1", 64'(ALU_D1), 64'd17);
            chk("div_alu_d2", 64'(ALU_D2), 64'd5);
            chk("div_rsp_quiet", 64'(RSP_VALID), 64'd0);
        end
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        @(negedge clock);
        chk("div_rsp_valid", 64'(RSP_VALID), 64'd2);
        chk("div_result", 64'(RSP_RESULT), 64'd3);
        chk("div_resto", 64'(RSP_RESTO), 64'd2);

        // Reset during a MUL abandons it; afterwards req0 wins a tie.
        do_reset();
        drive(0, 4'd2, 32'd6, 32'd7);
        REQ_VALID = 2'b01;
        @(negedge clock);
        chk("mul_ready", 64'(REQ_READY), 64'd1);
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("mulrst_no_rsp", 64'(RSP_VALID), 64'd0);
        end
        @(posedge clock); #1;
        drive(0, 4'd0, 32'd1, 32'd2);
        drive(1, 4'd0, 32'd3, 32'd4);
        REQ_VALID = 2'b11;
        @(negedge clock);
        chk("mulrst_tie", 64'(REQ_READY), 64'd1);
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        @(negedge clock);
        @(negedge clock);
        chk("mulrst_rsp_valid", 64'(RSP_VALID), 64'd1);
        chk("mulrst_result", 64'(RSP_RESULT), 64'd3);

        // Table of single operations.
        do_reset();
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Random traffic against the reference model, with one mid-run reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clock); #1;
            reset = (cyc == 300);
            REQ_VALID = 2'($urandom_range(0, 3));
            for (int n = 0; n < 2; n++) begin
                drive(n, 4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
        end
        @(posedge clock); #1;
        REQ_VALID = 2'b00;
        repeat (DIV_C + 4) @(posedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
